pedge_event_queue: RTL and testbench

Downstream consumer of the 8-bit positive-edge detector. Each cycle with a nonzero `pedge` vector becomes one event: the vector plus a free-running timestamp. Events are buffered in a small FIFO and handed to the next stage over a valid/ready interface. The block also reports overflow and counts dropped events.

---
 rtl/pedge_event_queue_pkg.sv | 14 +
 rtl/pedge_event_queue_fifo.sv | 59 +++++
 rtl/pedge_event_queue.sv | 75 +++++++
 tb/tb_pedge_event_queue.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pedge_event_queue_pkg.sv
// Shared types and constants for the edge-event queue.
// Event layout and drop-counter limit.
package pedge_pkg;

  localparam int DEFAULT_TS_W = 16;

  typedef struct packed {
    logic [DEFAULT_TS_W-1:0] stamp;
    logic [7:0]              bits;
  } pedge_event_t;

  localparam logic [7:0] DROP_MAX = 8'd255;

endpackage

// File: rtl/pedge_event_queue_fifo.sv
// Generic show-ahead synchronous FIFO.
// Head entry is visible on dout whenever the FIFO is not empty.
module event_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        level <= level + LW'(1);
      end else if (do_pop && !do_push) begin
        level <= level - LW'(1);
      end
    end
  end

endmodule

// File: rtl/pedge_event_queue.sv
// Turns nonzero edge vectors into timestamped events.
// Buffers them and tracks overflow and dropped-event count.
module pedge_event_queue
  import pedge_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TS_W  = DEFAULT_TS_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             pedge,
  input  logic                   clear_ovf,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [7:0]             out_bits,
  output logic [TS_W-1:0]        out_stamp,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);

  logic [TS_W-1:0]   ts;
  logic [TS_W+7:0]   dout;
  logic              full;
  logic              empty;
  logic              push_req;
  logic              pop;
  logic              accept;
  logic              drop;

  assign push_req  = |pedge;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign accept    = push_req && (!full || pop);
  assign drop      = push_req && !accept;
  assign out_stamp = dout[TS_W+7:8];
  assign out_bits  = dout[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_W'(1);
    end
  end

  // A clear in the same cycle as a drop wins; that drop is not counted.
  always_ff @(posedge clk) begin
    if (reset || clear_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != DROP_MAX) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  event_fifo #(
    .WIDTH (TS_W + 8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (pop),
    .din   ({ts, pedge}),
    .dout  (dout),
    .level (level),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_pedge_event_queue.sv
// Directed bench for pedge_event_queue with a scoreboard model.
// Uses a 4-bit timestamp so wraparound is reachable.
module tb_pedge_event_queue;

  localparam int DEPTH = 8;
  localparam int TS    = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [7:0]     pedge = '0;
  logic           clear_ovf = 1'b0;
  logic           out_ready = 1'b0;
  logic           out_valid;
  logic [7:0]     out_bits;
  logic [TS-1:0]  out_stamp;
  logic [3:0]     level;
  logic           overflow;
  logic [7:0]     drop_cnt;

  logic [TS+7:0]  q[$];
  logic [TS-1:0]  m_ts;
  logic           m_ovf;
  logic [7:0]     m_cnt;
  int             n_assert = 0;
  int             n_fail = 0;

  always #5 clk = ~clk;

  pedge_event_queue #(.DEPTH(DEPTH), .TS_W(TS)) dut (
    .clk       (clk),
    .reset     (reset),
    .pedge     (pedge),
    .clear_ovf (clear_ovf),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_bits  (out_bits),
    .out_stamp (out_stamp),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive, predict, clock, check.
  task automatic cyc(input logic [7:0] pe, input logic rdy,
                     input logic clr, input logic rst);
    logic pop_m;
    logic acc_m;
    pedge = pe;
    out_ready = rdy;
    clear_ovf = clr;
    reset = rst;
    #1;
    if (rst) begin
      q.delete();
      m_ts = '0;
      m_ovf = 1'b0;
      m_cnt = '0;
    end else begin
      if (q.size() != 0) begin
        chk("head", {20'd0, out_stamp, out_bits}, {20'd0, q[0]});
      end
      pop_m = (q.size() != 0) && rdy;
      acc_m = (pe != 0) && (q.size() < DEPTH || pop_m);
      if (pop_m) void'(q.pop_front());
      if (acc_m) q.push_back({m_ts, pe});
      if (clr) begin
        m_ovf = 1'b0;
        m_cnt = '0;
      end else if (pe != 0 && !acc_m) begin
        m_ovf = 1'b1;
        if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
      end
      m_ts = m_ts + 4'd1;
    end
    @(posedge clk);
    #1;
    chk("level", 32'(level), 32'(q.size()));
    chk("valid", 32'(out_valid), 32'(q.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    cyc(8'h00, 1'b1, 1'b0, 1'b1);
    cyc(8'h00, 1'b1, 1'b0, 1'b1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_cnt", 32'(drop_cnt), 32'd0);

    // Single event at the 5th edge after reset
    for (int i = 0; i < 4; i++) cyc(8'h00, 1'b1, 1'b0, 1'b0);
    cyc(8'h01, 1'b1, 1'b0, 1'b0);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_bits", 32'(out_bits), 32'h01);
    chk("single_stamp", 32'(out_stamp), 32'd4);
    cyc(8'h00, 1'b1, 1'b0, 1'b0);
    chk("single_gone", 32'(out_valid), 32'd0);

    // Backpressure fill and drop
    for (int i = 0; i < 10; i++) cyc(8'h80, 1'b0, 1'b0, 1'b0);
    chk("fill_level", 32'(level), 32'd8);
    chk("fill_ovf", 32'(overflow), 32'd1);
    chk("fill_cnt", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 8; i++) cyc(8'h00, 1'b1, 1'b0, 1'b0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) cyc(8'h80, 1'b0, 1'b0, 1'b0);
    cyc(8'h0F, 1'b1, 1'b0, 1'b0);
    chk("pp_level", 32'(level), 32'd8);
    chk("pp_cnt", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 7; i++) cyc(8'h00, 1'b1, 1'b0, 1'b0);
    chk("pp_last", 32'(out_bits), 32'h0F);
    cyc(8'h00, 1'b1, 1'b0, 1'b0);

    // Zero vectors are ignored
    for (int i = 0; i < 100; i++) cyc(8'h00, 1'b1, 1'b0, 1'b0);
    chk("zero_level", 32'(level), 32'd0);
    chk("zero_cnt", 32'(drop_cnt), 32'd2);

    // Saturation, then clear coinciding with a drop
    for (int i = 0; i < 300; i++) begin
      cyc(8'($urandom_range(1, 255)), 1'b0, 1'b0, 1'b0);
    end
    chk("sat_cnt", 32'(drop_cnt), 32'd255);
    cyc(8'h55, 1'b0, 1'b1, 1'b0);
    chk("clr_cnt", 32'(drop_cnt), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) cyc(8'h00, 1'b1, 1'b0, 1'b0);

    // Timestamp wrap
    for (int i = 0; i < 16 && m_ts != 4'hF; i++) cyc(8'h00, 1'b1, 1'b0, 1'b0);
    cyc(8'h33, 1'b0, 1'b0, 1'b0);
    cyc(8'h44, 1'b0, 1'b0, 1'b0);
    chk("wrap_first", 32'(out_stamp), 32'hF);
    cyc(8'h00, 1'b1, 1'b0, 1'b0);
    chk("wrap_second", 32'(out_stamp), 32'h0);
    cyc(8'h00, 1'b1, 1'b0, 1'b0);

    // Mid-run reset with buffered events
    for (int i = 0; i < 5; i++) cyc(8'h02, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd5);
    cyc(8'h07, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    cyc(8'h09, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_ts", 32'(out_stamp), 32'd0);
    chk("mid_rst_bits", 32'(out_bits), 32'h09);
    cyc(8'h00, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
